// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN flags misaligned redirect targets instead of aligning them.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_x,
   input  logic [1:0]  i_PCSrc,
   input  logic [31:0] i_targetE,
   input  logic [31:0] i_jalrTargetE,
   input  logic [31:0] i_trapVector,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic        o_imemReq,
   output logic [31:0] o_imemAddr,
   input  logic        i_imemReady,
   input  logic [31:0] i_imemData,
   output logic [31:0] o_inst,
   output logic [31:0] o_pcD,
   output logic [31:0] o_pcPlus4D,
   output logic        o_validD,
   output logic        o_fetchBusy
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        o_misalignD
`endif
);

   typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_skid;
   logic [31:0] r_inst;
   logic [31:0] r_pcD;
   logic [31:0] r_pcPlus4D;
   logic        r_validD;

   logic [31:0] w_rawTarget;
   logic [31:0] w_target;
   logic [31:0] w_pcPlus4;
   logic        w_redirect;
   logic        w_misTarget;
   logic        w_misWait;
   logic        w_reqActive;

   always_comb begin
      w_rawTarget = r_pc;
      case (i_PCSrc)
         2'b01:   w_rawTarget = i_targetE;
         2'b10:   w_rawTarget = i_jalrTargetE;
         2'b11:   w_rawTarget = i_trapVector;
         default: w_rawTarget = r_pc;
      endcase
   end

   assign w_redirect = (r_state != BOOT) && (i_PCSrc != 2'b00);
   assign w_pcPlus4  = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_misWait;
   logic r_misD;
   assign w_target    = w_rawTarget;
   assign w_misTarget = w_redirect && (w_rawTarget[1:0] != 2'b00);
   assign w_misWait   = r_misWait;
   assign o_misalignD = r_misD;
`else
   assign w_target    = w_rawTarget & ~32'h0000_0003;
   assign w_misTarget = 1'b0;
   assign w_misWait   = 1'b0;
`endif

   // A misaligned redirect parks the stage in REQ with the request suppressed.
   assign w_reqActive = (r_state == REQ) && !w_misWait;
   assign o_imemReq   = w_reqActive;
   assign o_fetchBusy = w_reqActive && !i_imemReady;
   assign o_imemAddr  = r_pc;
   assign o_inst      = r_inst;
   assign o_pcD       = r_pcD;
   assign o_pcPlus4D  = r_pcPlus4D;
   assign o_validD    = r_validD;

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_state    <= BOOT;
         r_pc       <= RESET_PC;
         r_skid     <= '0;
         r_inst     <= NOP_INST;
         r_pcD      <= '0;
         r_pcPlus4D <= '0;
         r_validD   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_misWait  <= 1'b0;
         r_misD     <= 1'b0;
`endif
      end else begin
         if (w_redirect) begin
            r_pc     <= w_target;
            r_state  <= REQ;
            r_skid   <= '0;
            r_inst   <= NOP_INST;
            r_validD <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misWait <= w_misTarget;
            r_misD    <= w_misTarget;
            if (w_misTarget) begin
               r_pcD      <= w_target;
               r_pcPlus4D <= w_target + 32'd4;
            end
`endif
         end else begin
            case (r_state)
               BOOT: r_state <= REQ;
               REQ: begin
                  if (!w_misWait) begin
                     if (i_imemReady && !i_stall) begin
                        r_inst     <= i_imemData;
                        r_pcD      <= r_pc;
                        r_pcPlus4D <= w_pcPlus4;
                        r_validD   <= 1'b1;
                        r_pc       <= w_pcPlus4;
                     end else if (i_imemReady) begin
                        r_skid  <= i_imemData;
                        r_state <= HOLD;
                     end else if (!i_stall) begin
                        r_inst   <= NOP_INST;
                        r_validD <= 1'b0;
                     end
                  end
               end
               HOLD: begin
                  if (!i_stall) begin
                     r_inst     <= r_skid;
                     r_pcD      <= r_pc;
                     r_pcPlus4D <= w_pcPlus4;
                     r_validD   <= 1'b1;
                     r_pc       <= w_pcPlus4;
                     r_state    <= REQ;
                  end
               end
               default: r_state <= BOOT;
            endcase
         end
         // Flush wins over every IF/ID load above, including the misalign marker.
         if (i_flush) begin
            r_inst   <= NOP_INST;
            r_validD <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misD   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus an IF/ID scoreboard,
// followed by hand-written misalign and mid-request reset sequences.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset_x;
   logic [1:0]  i_PCSrc;
   logic [31:0] i_targetE;
   logic [31:0] i_jalrTargetE;
   logic [31:0] i_trapVector;
   logic        i_stall;
   logic        i_flush;
   logic        o_imemReq;
   logic [31:0] o_imemAddr;
   logic        i_imemReady;
   logic [31:0] i_imemData;
   logic [31:0] o_inst;
   logic [31:0] o_pcD;
   logic [31:0] o_pcPlus4D;
   logic        o_validD;
   logic        o_fetchBusy;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        o_misalignD;
`endif

   fetch_stage dut (
      .clk           (clk),
      .reset_x       (reset_x),
      .i_PCSrc       (i_PCSrc),
      .i_targetE     (i_targetE),
      .i_jalrTargetE (i_jalrTargetE),
      .i_trapVector  (i_trapVector),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_imemReq     (o_imemReq),
      .o_imemAddr    (o_imemAddr),
      .i_imemReady   (i_imemReady),
      .i_imemData    (i_imemData),
      .o_inst        (o_inst),
      .o_pcD         (o_pcD),
      .o_pcPlus4D    (o_pcPlus4D),
      .o_validD      (o_validD),
      .o_fetchBusy   (o_fetchBusy)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .o_misalignD   (o_misalignD)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy, stl, fl;
      logic [1:0]  src;
      logic [31:0] tgt, data;
      logic        expReq, expBusy;
      logic [31:0] expAddr;
      logic        expValid, load, expNop;
      logic [31:0] expInst;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sb_t;

   vec_t vecs[23];
   sb_t  sbq[$];
   int   testsRun = 0;
   int   failCount = 0;

   function automatic vec_t v(input logic rdy, stl, fl, input logic [1:0] src,
                              input logic [31:0] tgt, data, input logic expReq, expBusy,
                              input logic [31:0] expAddr, input logic expValid, load, expNop,
                              input logic [31:0] expInst);
      vec_t t;
      t.rdy = rdy; t.stl = stl; t.fl = fl; t.src = src; t.tgt = tgt; t.data = data;
      t.expReq = expReq; t.expBusy = expBusy; t.expAddr = expAddr;
      t.expValid = expValid; t.load = load; t.expNop = expNop; t.expInst = expInst;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Unselected target inputs carry aligned decoys so a wrong mux leg is visible.
   task automatic applyStimulus(input vec_t t);
      i_imemReady   = t.rdy;
      i_stall       = t.stl;
      i_flush       = t.fl;
      i_PCSrc       = t.src;
      i_targetE     = (t.src == 2'b01) ? t.tgt : 32'h0000_0A00;
      i_jalrTargetE = (t.src == 2'b10) ? t.tgt : 32'h0000_0B00;
      i_trapVector  = (t.src == 2'b11) ? t.tgt : 32'h0000_0C00;
      i_imemData    = t.data;
      if (t.load) sbq.push_back('{pc: t.expAddr, inst: t.expInst});
   endtask

   task automatic idleInputs();
      applyStimulus(v(0,0,0,2'b00,32'h0,32'h0, 0,0,0, 0,0,0,32'h0));
   endtask

   task automatic checkResetState();
      checkOutput("rst_imemReq", {31'b0, o_imemReq}, 32'd0);
      checkOutput("rst_fetchBusy", {31'b0, o_fetchBusy}, 32'd0);
      checkOutput("rst_imemAddr", o_imemAddr, 32'h0);
      checkOutput("rst_inst", o_inst, NOP);
      checkOutput("rst_validD", {31'b0, o_validD}, 32'd0);
      checkOutput("rst_pcD", o_pcD, 32'h0);
      checkOutput("rst_pcPlus4D", o_pcPlus4D, 32'h0);
   endtask

   initial begin
      sb_t e;
      vecs[0]  = v(1,0,0,2'b00,32'h0,32'h0000_0093, 0,0,32'h0,   0,0,1,32'h0);
      vecs[1]  = v(1,0,0,2'b00,32'h0,32'h0000_0093, 1,0,32'h0,   1,1,0,32'h0000_0093);
      vecs[2]  = v(1,0,0,2'b00,32'h0,32'h0000_0093, 1,0,32'h4,   1,1,0,32'h0000_0093);
      vecs[3]  = v(1,0,0,2'b00,32'h0,32'h0000_0093, 1,0,32'h8,   1,1,0,32'h0000_0093);
      vecs[4]  = v(1,0,0,2'b01,32'h8,32'hDEAD_BEEF, 1,0,32'hC,   0,0,1,32'h0);
      vecs[5]  = v(0,0,0,2'b00,32'h0,32'h0,         1,1,32'h8,   0,0,1,32'h0);
      vecs[6]  = v(0,0,0,2'b00,32'h0,32'h0,         1,1,32'h8,   0,0,1,32'h0);
      vecs[7]  = v(0,0,0,2'b00,32'h0,32'h0,         1,1,32'h8,   0,0,1,32'h0);
      vecs[8]  = v(1,0,0,2'b00,32'h0,32'h0080_0113, 1,0,32'h8,   1,1,0,32'h0080_0113);
      vecs[9]  = v(1,1,0,2'b00,32'h0,32'h00C0_0193, 1,0,32'hC,   1,0,0,32'h0);
      vecs[10] = v(1,1,0,2'b00,32'h0,32'hBAD0_BAD0, 0,0,32'hC,   1,0,0,32'h0);
      vecs[11] = v(1,0,0,2'b00,32'h0,32'hBAD0_BAD0, 0,0,32'hC,   1,1,0,32'h00C0_0193);
      vecs[12] = v(1,0,0,2'b00,32'h0,32'h0100_0213, 1,0,32'h10,  1,1,0,32'h0100_0213);
      vecs[13] = v(1,1,0,2'b00,32'h0,32'h0140_0293, 1,0,32'h14,  1,0,0,32'h0);
      vecs[14] = v(1,1,1,2'b01,32'h100,32'hBAD0_BAD0, 0,0,32'h14, 0,0,1,32'h0);
      vecs[15] = v(1,0,0,2'b00,32'h0,32'h1000_0313, 1,0,32'h100, 1,1,0,32'h1000_0313);
      vecs[16] = v(0,0,0,2'b10,32'hFFFF_FFFC,32'h0, 1,1,32'h104, 0,0,1,32'h0);
      vecs[17] = v(1,0,0,2'b00,32'h0,32'h7FF0_0393, 1,0,32'hFFFF_FFFC, 1,1,0,32'h7FF0_0393);
      vecs[18] = v(1,0,0,2'b00,32'h0,32'h0000_0413, 1,0,32'h0,   1,1,0,32'h0000_0413);
      vecs[19] = v(1,0,0,2'b11,32'h300,32'hBAD0_BAD0, 1,0,32'h4, 0,0,1,32'h0);
      vecs[20] = v(1,0,1,2'b00,32'h0,32'h0000_00FF, 1,0,32'h300, 0,0,1,32'h0);
      vecs[21] = v(1,0,0,2'b00,32'h0,32'h0050_0513, 1,0,32'h304, 1,1,0,32'h0050_0513);
      vecs[22] = v(0,1,0,2'b00,32'h0,32'h0,         1,1,32'h308, 1,0,0,32'h0);

      reset_x = 1'b0;
      idleInputs();
      #12;
      checkResetState();
      @(posedge clk);
      #2 reset_x = 1'b1;

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d_imemReq", i), {31'b0, o_imemReq}, {31'b0, vecs[i].expReq});
         checkOutput($sformatf("v%0d_fetchBusy", i), {31'b0, o_fetchBusy}, {31'b0, vecs[i].expBusy});
         checkOutput($sformatf("v%0d_imemAddr", i), o_imemAddr, vecs[i].expAddr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_validD", i), {31'b0, o_validD}, {31'b0, vecs[i].expValid});
         if (vecs[i].expNop) checkOutput($sformatf("v%0d_bubbleInst", i), o_inst, NOP);
         if (vecs[i].load) begin
            if (sbq.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL v%0d_scoreboard: got empty queue expected entry", i);
            end else begin
               e = sbq.pop_front();
               checkOutput($sformatf("v%0d_inst", i), o_inst, e.inst);
               checkOutput($sformatf("v%0d_pcD", i), o_pcD, e.pc);
               checkOutput($sformatf("v%0d_pcPlus4D", i), o_pcPlus4D, e.pc + 32'd4);
            end
         end
      end

      // Misaligned jalr target.
      @(negedge clk);
      applyStimulus(v(0,0,0,2'b10,32'h202,32'h0, 0,0,0, 0,0,0,32'h0));
      @(posedge clk);
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      checkOutput("mis_imemReq", {31'b0, o_imemReq}, 32'd0);
      checkOutput("mis_misalignD", {31'b0, o_misalignD}, 32'd1);
      checkOutput("mis_pcD", o_pcD, 32'h202);
      checkOutput("mis_validD", {31'b0, o_validD}, 32'd0);
      checkOutput("mis_imemAddr", o_imemAddr, 32'h202);
      @(negedge clk);
      applyStimulus(v(1,0,0,2'b00,32'h0,32'hBAD0_BAD0, 0,0,0, 0,0,0,32'h0));
      #1;
      checkOutput("misWait_fetchBusy", {31'b0, o_fetchBusy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("misWait_imemReq", {31'b0, o_imemReq}, 32'd0);
      checkOutput("misWait_misalignD", {31'b0, o_misalignD}, 32'd1);
      checkOutput("misWait_validD", {31'b0, o_validD}, 32'd0);
      @(negedge clk);
      applyStimulus(v(0,0,0,2'b01,32'h400,32'h0, 0,0,0, 0,0,0,32'h0));
      @(posedge clk);
      #1;
      checkOutput("misExit_imemReq", {31'b0, o_imemReq}, 32'd1);
      checkOutput("misExit_imemAddr", o_imemAddr, 32'h400);
      checkOutput("misExit_misalignD", {31'b0, o_misalignD}, 32'd0);
`else
      checkOutput("align_imemAddr", o_imemAddr, 32'h200);
      checkOutput("align_imemReq", {31'b0, o_imemReq}, 32'd1);
      checkOutput("align_validD", {31'b0, o_validD}, 32'd0);
`endif

      // Reset dropped in the middle of an outstanding request.
      @(negedge clk);
      idleInputs();
      #2 reset_x = 1'b0;
      #1;
      checkResetState();
      i_imemReady = 1'b1;
      i_imemData  = 32'h1234_5677;
      @(posedge clk);
      #1;
      checkResetState();
      #1 reset_x = 1'b1;
      @(negedge clk);
      i_imemData = 32'hEEEE_0013;
      #1;
      checkOutput("boot_imemReq", {31'b0, o_imemReq}, 32'd0);
      checkOutput("boot_fetchBusy", {31'b0, o_fetchBusy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("boot_validD", {31'b0, o_validD}, 32'd0);
      checkOutput("boot_inst", o_inst, NOP);
      checkOutput("first_imemReq", {31'b0, o_imemReq}, 32'd1);
      checkOutput("first_imemAddr", o_imemAddr, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("first_validD", {31'b0, o_validD}, 32'd1);
      checkOutput("first_pcD", o_pcD, 32'h0);
      checkOutput("first_inst", o_inst, 32'hEEEE_0013);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
